// File: rtl/dot_accel.sv
// Avalon-MM Q16.16 dot-product engine: fetches weight/activation vectors over
// the master port and multiply-accumulates them. DOT_ACCEL_RELU_EN fuses a ReLU onto RESULT.
module dot_accel #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_W   = 3'd1;
  localparam logic [2:0] S_WAIT_W = 3'd2;
  localparam logic [2:0] S_RD_A   = 3'd3;
  localparam logic [2:0] S_WAIT_A = 3'd4;
  localparam logic [2:0] S_MAC    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] OFS_CTRL   = 4'd0;
  localparam logic [3:0] OFS_W_ADDR = 4'd2;
  localparam logic [3:0] OFS_A_ADDR = 4'd3;
  localparam logic [3:0] OFS_LEN    = 4'd5;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        done_hold;
  logic [31:0] w_addr;
  logic [31:0] a_addr;
  logic [31:0] len;
  logic [31:0] result;
  logic [31:0] acc;
  logic [31:0] ptr_w;
  logic [31:0] ptr_a;
  logic [31:0] cnt;
  logic [31:0] w_val;
  logic [31:0] a_val;

  logic               cpu_ok;
  logic               start;
  logic signed [63:0] product;
  logic [31:0]        mac_term;

  // The CPU is only served in IDLE once the post-DONE cycle has passed, so a
  // stalled read of offset 0 always completes with the freshly written RESULT.
  assign cpu_ok = (state == S_IDLE) && !done_hold;
  assign start  = cpu_ok && slave_write && (slave_address == OFS_CTRL);

  // Arithmetic shift of the signed product floors toward -inf.
  assign product  = $signed(w_val) * $signed(a_val);
  assign mac_term = 32'(product >>> FRAC_BITS);

  assign slave_waitrequest = (state != S_IDLE) || done_hold;
  assign master_read       = (state == S_RD_W) || (state == S_RD_A);
  assign master_write      = 1'b0;
  assign master_writedata  = '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    master_address = '0;
    if (state == S_RD_W) begin
      master_address = ptr_w;
    end else if (state == S_RD_A) begin
      master_address = ptr_a;
    end
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        OFS_CTRL:   slave_readdata = result;
        OFS_W_ADDR: slave_readdata = w_addr;
        OFS_A_ADDR: slave_readdata = a_addr;
        OFS_LEN:    slave_readdata = len;
        default:    slave_readdata = '0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? S_DONE : S_RD_W;
        end
      end
      S_RD_W: begin
        if (!master_waitrequest) begin
          state_next = S_WAIT_W;
        end
      end
      S_WAIT_W: begin
        if (master_readdatavalid) begin
          state_next = S_RD_A;
        end
      end
      S_RD_A: begin
        if (!master_waitrequest) begin
          state_next = S_WAIT_A;
        end
      end
      S_WAIT_A: begin
        if (master_readdatavalid) begin
          state_next = S_MAC;
        end
      end
      S_MAC:   state_next = (cnt == 32'd1) ? S_DONE : S_RD_W;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      done_hold <= 1'b0;
      w_addr    <= '0;
      a_addr    <= '0;
      len       <= '0;
      result    <= '0;
      acc       <= '0;
      ptr_w     <= '0;
      ptr_a     <= '0;
      cnt       <= '0;
      w_val     <= '0;
      a_val     <= '0;
    end else begin
      state     <= state_next;
      done_hold <= (state == S_DONE);

      if (cpu_ok && slave_write) begin
        case (slave_address)
          OFS_W_ADDR: w_addr <= slave_writedata;
          OFS_A_ADDR: a_addr <= slave_writedata;
          OFS_LEN:    len    <= slave_writedata;
          default:    ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            ptr_w <= w_addr;
            ptr_a <= a_addr;
            cnt   <= len;
          end
        end
        S_WAIT_W: begin
          if (master_readdatavalid) begin
            w_val <= master_readdata;
          end
        end
        S_WAIT_A: begin
          if (master_readdatavalid) begin
            a_val <= master_readdata;
          end
        end
        S_MAC: begin
          acc   <= acc + mac_term;
          ptr_w <= ptr_w + 32'd4;
          ptr_a <= ptr_a + 32'd4;
          cnt   <= cnt - 32'd1;
        end
        S_DONE: begin
`ifdef DOT_ACCEL_RELU_EN
          result <= acc[31] ? '0 : acc;
`else
          result <= acc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accel.sv
// Self-checking bench for dot_accel: SDRAM responder, fixed-point reference
// model with address scoreboard, and directed cases with literal results.
module tb_dot_accel;

  localparam int FRAC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  dot_accel #(.FRAC_BITS(FRAC)) dut (
    .clk                  (clk),
    .reset                (reset),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_result = '0;
  logic [31:0] wv [4];
  logic [31:0] av [4];

  int          stall_left  = 0;
  int          lat         = 1;
  int          resp_cnt    = 0;
  logic [31:0] resp_addr   = '0;
  int          accept_count = 0;
  int          rd_cycles   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference: signed Q-format products floored to FRAC bits, summed with 32-bit wrap.
  function automatic logic [31:0] model_dot(input int n);
    int     acc;
    longint prod;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      prod = longint'($signed(wv[i])) * longint'($signed(av[i]));
      acc += int'(prod >>> FRAC);
    end
`ifdef DOT_ACCEL_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  // SDRAM responder: optional initial stall, fixed read latency, one read in flight.
  initial begin
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = mem.exists(resp_addr) ? mem[resp_addr] : 32'hDEAD_BEEF;
        end
      end
      if (master_read && !reset) begin
        rd_cycles++;
        if (stall_left > 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
        end else begin
          master_waitrequest = 1'b0;
          resp_addr = master_address;
          resp_cnt = lat;
          accept_count++;
        end
      end else begin
        master_waitrequest = 1'b0;
      end
    end
  end

  // Compare process: master side against the address scoreboard, slave reads against the model.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] e;
    prev_stall = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      check("mwr_tied", master_writedata | {31'b0, master_write}, 32'h0);
      if (prev_stall) begin
        check("hold_read", {31'b0, master_read}, 32'h1);
        check("hold_addr", master_address, prev_addr);
      end
      prev_stall = master_read && master_waitrequest;
      prev_addr = master_address;
      if (master_read && !master_waitrequest && !reset) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_addr: unexpected read of %h at %0t", master_address, $time);
        end else begin
          e = exp_addr.pop_front();
          check("rd_addr", master_address, e);
        end
      end
      if (!reset && slave_read && !slave_waitrequest && slave_address == 4'd0) begin
        check("result_model", slave_readdata, exp_result);
      end
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!slave_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    slave_write = 1'b0;
    slave_address = '0;
    slave_writedata = '0;
    if (!ok) timeout_fail("cpu_write");
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    bit ok;
    ok = 1'b0;
    d = 'x;
    slave_address = a;
    slave_read = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!slave_waitrequest) begin
        d = slave_readdata;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    slave_read = 1'b0;
    slave_address = '0;
    if (!ok) timeout_fail("cpu_read");
  endtask

  task automatic load_case(input logic [31:0] wa, input logic [31:0] aa, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wa + 32'(4 * i)] = wv[i];
      mem[aa + 32'(4 * i)] = av[i];
      exp_addr.push_back(wa + 32'(4 * i));
      exp_addr.push_back(aa + 32'(4 * i));
    end
    cpu_write(4'd2, wa);
    cpu_write(4'd3, aa);
    cpu_write(4'd5, 32'(n));
  endtask

  task automatic run_case(input string name, input logic [31:0] wa, input logic [31:0] aa,
                          input int n, input int stall, input int latency, input logic [31:0] lit);
    logic [31:0] r;
    load_case(wa, aa, n);
    stall_left = stall;
    lat = latency;
    cpu_write(4'd0, 32'h0);
    exp_result = model_dot(n);
    cpu_read(4'd0, r);
    check(name, r, lit);
    check("addrs_left", 32'(exp_addr.size()), 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    int          base;
    int          wr_cnt;
    bit          hit;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          base;
    int          wr_cnt;
    bit          hit;

    // Reset state
    slave_read = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_waitreq", {31'b0, slave_waitrequest}, 32'h0);
    check("rst_mread", {31'b0, master_read}, 32'h0);
    check("rst_maddr", master_address, 32'h0);
    check("rst_result", slave_readdata, 32'h0);
    slave_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 2.0 * 1.5
    wv[0] = 32'h0002_0000; av[0] = 32'h0001_8000;
    run_case("single_pos", 32'h1000, 32'h2000, 1, 0, 1, 32'h0003_0000);

    // -1.0 * 2.5
    wv[0] = 32'hFFFF_0000; av[0] = 32'h0002_8000;
`ifdef DOT_ACCEL_RELU_EN
    run_case("neg_prod", 32'h1000, 32'h2000, 1, 0, 1, 32'h0000_0000);
`else
    run_case("neg_prod", 32'h1000, 32'h2000, 1, 0, 1, 32'hFFFD_8000);
`endif

    // -2^-16 * 0.5 floors to -1 LSB
    wv[0] = 32'hFFFF_FFFF; av[0] = 32'h0000_8000;
`ifdef DOT_ACCEL_RELU_EN
    run_case("trunc_floor", 32'h1100, 32'h2100, 1, 0, 2, 32'h0000_0000);
`else
    run_case("trunc_floor", 32'h1100, 32'h2100, 1, 0, 2, 32'hFFFF_FFFF);
`endif

    // {1,2,3} . {0.5,0.5,0.5}
    wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000; wv[2] = 32'h0003_0000;
    av[0] = 32'h0000_8000; av[1] = 32'h0000_8000; av[2] = 32'h0000_8000;
    run_case("len3", 32'h1000, 32'h2000, 3, 0, 1, 32'h0003_0000);

    // LEN=0: no master traffic, waitrequest high for exactly two cycles
    cpu_write(4'd5, 32'h0);
    base = rd_cycles;
    cpu_write(4'd0, 32'h0);
    exp_result = model_dot(0);
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (slave_waitrequest) wr_cnt++;
      else break;
    end
    check("len0_wait", 32'(wr_cnt), 32'd2);
    check("len0_noread", 32'(rd_cycles - base), 32'd0);
    @(posedge clk);
    #1;
    cpu_read(4'd0, r);
    check("len0_result", r, 32'h0);

    // Same length-3 vector with a 5-cycle stall on the first read
    run_case("stall5", 32'h1000, 32'h2000, 3, 5, 1, 32'h0003_0000);

    // Address wrap past 2^32 and accumulator wrap to 0x80000000
    wv[0] = 32'h0001_0000; wv[1] = 32'h0001_0000;
    av[0] = 32'h4000_0000; av[1] = 32'h4000_0000;
`ifdef DOT_ACCEL_RELU_EN
    run_case("wrap", 32'hFFFF_FFFC, 32'h3000, 2, 0, 1, 32'h0000_0000);
`else
    run_case("wrap", 32'hFFFF_FFFC, 32'h3000, 2, 0, 1, 32'h8000_0000);
`endif

    // Reset pulsed while waiting on the activation word
    wv[0] = 32'h0002_0000; av[0] = 32'h0001_8000;
    load_case(32'h1000, 32'h2000, 1);
    lat = 4;
    base = accept_count;
    cpu_write(4'd0, 32'h0);
    exp_result = model_dot(1);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (accept_count == base + 2) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) timeout_fail("reach_wait_a");
    @(posedge clk);
    #3;
    exp_addr.delete();
    exp_result = '0;
    reset = 1'b1;
    #1;
    check("rst_mid_mread", {31'b0, master_read}, 32'h0);
    check("rst_mid_waitreq", {31'b0, slave_waitrequest}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lat = 1;
    repeat (6) @(posedge clk);
    #1;
    cpu_read(4'd0, r);
    check("rst_mid_result", r, 32'h0);
    cpu_read(4'd2, r);
    check("rst_mid_w_addr", r, 32'h0);
    cpu_read(4'd3, r);
    check("rst_mid_a_addr", r, 32'h0);
    cpu_read(4'd5, r);
    check("rst_mid_len", r, 32'h0);

    run_case("post_reset", 32'h1000, 32'h2000, 1, 0, 1, 32'h0003_0000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
